// File: rtl/cmp_pkg.sv
// Shared definitions for the windowed min/max block: FSM state encoding,
// default sizing constants and a counter-width helper.
package cmp_pkg;

  // Window collection phase vs. result presentation phase.
  typedef enum logic {
    FILL = 1'b0,
    OUT  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_WIN   = 8;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mag_cmp.sv
// Unsigned magnitude comparator: reports a > b, a == b and a < b at full width.
module mag_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // Pure combinational compare; both operands are unsigned.
  always_comb begin
    gt = (a > b);
    eq = (a == b);
    lt = (a < b);
  end

endmodule

// File: rtl/window_minmax.sv
// Windowed min/max tracker. Collects WIN accepted samples, then presents the
// smallest and largest of them until the consumer takes the result.
// Optional feature: define WINDOW_MINMAX_EQ_CNT_EN to add the eq_cnt output,
// which counts non-first samples equal to the running maximum.
module window_minmax
  import cmp_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int WIN   = DEF_WIN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_min,
  output logic [WIDTH-1:0]           out_max
`ifdef WINDOW_MINMAX_EQ_CNT_EN
  ,
  output logic [$clog2(WIN+1)-1:0]   eq_cnt
`endif
);

  localparam int              CNT_W = cnt_width(WIN);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIN - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] min_reg, min_next;
  logic [WIDTH-1:0] max_reg, max_next;
  logic             accept;
  logic             first;

  logic max_gt, max_eq, max_lt;
  logic min_gt, min_eq, min_lt;

  // Sample against the running maximum.
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a  (in_data),
    .b  (max_reg),
    .gt (max_gt),
    .eq (max_eq),
    .lt (max_lt)
  );

  // Sample against the running minimum.
  mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a  (in_data),
    .b  (min_reg),
    .gt (min_gt),
    .eq (min_eq),
    .lt (min_lt)
  );

  assign first = (cnt_reg == '0);

  // Next-state, handshake outputs and running min/max update.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    min_next   = min_reg;
    max_next   = max_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      FILL: begin
        // Reset masks the handshake outputs regardless of state.
        in_ready = !rst;
        accept   = in_valid && !rst;
        if (accept) begin
          if (first) begin
            min_next = in_data;
            max_next = in_data;
          end else begin
            // Ties leave the extremes untouched.
            if (max_gt) max_next = in_data;
            if (min_lt) min_next = in_data;
          end
          if (cnt_reg == LAST) begin
            cnt_next   = '0;
            state_next = OUT;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end
      OUT: begin
        out_valid = !rst;
        if (out_ready && !rst) state_next = FILL;
      end
      default: state_next = FILL;
    endcase
  end

  // State and datapath registers; reset drops any partial or pending window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FILL;
      cnt_reg   <= '0;
      min_reg   <= '0;
      max_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      min_reg   <= min_next;
      max_reg   <= max_next;
    end
  end

  assign out_min = min_reg;
  assign out_max = max_reg;

`ifdef WINDOW_MINMAX_EQ_CNT_EN
  localparam int EQ_W = $clog2(WIN + 1);

  logic [EQ_W-1:0] eq_reg, eq_next;

  // Count later samples that tie the maximum as it stood before this sample.
  always_comb begin
    eq_next = eq_reg;
    if (accept) begin
      if (first) eq_next = '0;
      else if (max_eq) eq_next = eq_reg + 1'b1;
    end
  end

  // Tie counter register; held with the result until the next window starts.
  always_ff @(posedge clk) begin
    if (rst) eq_reg <= '0;
    else     eq_reg <= eq_next;
  end

  assign eq_cnt = eq_reg;

  logic cmp_unused;
  assign cmp_unused = ^{max_lt, min_gt, min_eq};
`else
  logic cmp_unused;
  assign cmp_unused = ^{max_eq, max_lt, min_gt, min_eq};
`endif

endmodule

// File: tb/tb_window_minmax.sv
// Randomized and directed bench for window_minmax (WIN=4, WIDTH=4) against a
// queue-based reference model.
module tb_window_minmax;

  localparam int WIDTH = 4;
  localparam int WIN   = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
`ifdef WINDOW_MINMAX_EQ_CNT_EN
  logic [$clog2(WIN+1)-1:0] eq_cnt;
`endif

  window_minmax #(.WIDTH(WIDTH), .WIN(WIN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_max   (out_max)
`ifdef WINDOW_MINMAX_EQ_CNT_EN
    ,
    .eq_cnt    (eq_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit mdl_out = 1'b0;
  int win_q[$];
  int exp_min = 0;
  int exp_max = 0;
  int exp_eq  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, check outputs, advance the model.
  task automatic drive(input bit r, input bit iv, input int d, input bit ordy);
    int v;
    rst       = r;
    in_valid  = iv;
    in_data   = d[WIDTH-1:0];
    out_ready = ordy;
    v         = d % (1 << WIDTH);
    #1;
    check_val("in_ready", int'(in_ready), int'(!r && !mdl_out));
    check_val("out_valid", int'(out_valid), int'(!r && mdl_out));
    if (!r && mdl_out) begin
      check_val("out_min", int'(out_min), exp_min);
      check_val("out_max", int'(out_max), exp_max);
`ifdef WINDOW_MINMAX_EQ_CNT_EN
      check_val("eq_cnt", int'(eq_cnt), exp_eq);
`endif
    end
    if (!r && !mdl_out && iv)
      $display("accept data=%0d fill=%0d", v, win_q.size() + 1);
    if (!r && mdl_out && ordy)
      $display("result min=%0d max=%0d eq=%0d", exp_min, exp_max, exp_eq);

    if (r) begin
      mdl_out = 1'b0;
      win_q.delete();
    end else if (!mdl_out) begin
      if (iv) begin
        win_q.push_back(v);
        if (win_q.size() == WIN) begin
          exp_min = win_q[0];
          exp_max = win_q[0];
          exp_eq  = 0;
          for (int i = 1; i < WIN; i++) begin
            if (win_q[i] == exp_max) exp_eq++;
            if (win_q[i] > exp_max) exp_max = win_q[i];
            if (win_q[i] < exp_min) exp_min = win_q[i];
          end
          mdl_out = 1'b1;
          win_q.delete();
        end
      end
    end else if (ordy) begin
      mdl_out = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_window(input int a, input int b, input int c, input int d);
    drive(1'b0, 1'b1, a, 1'b1);
    drive(1'b0, 1'b1, b, 1'b1);
    drive(1'b0, 1'b1, c, 1'b1);
    drive(1'b0, 1'b1, d, 1'b1);
    drive(1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    drive(1'b1, 1'b1, 9, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b0);
    check_val("rst_min", int'(out_min), 0);
    check_val("rst_max", int'(out_max), 0);
`ifdef WINDOW_MINMAX_EQ_CNT_EN
    check_val("rst_eq", int'(eq_cnt), 0);
`endif

    // Directed windows.
    send_window(5, 2, 9, 7);
    send_window(6, 6, 6, 6);
    send_window(15, 0, 15, 0);

    // Back-pressure in OUT with in_valid held high; those samples are dropped.
    drive(1'b0, 1'b1, 1, 1'b0);
    drive(1'b0, 1'b1, 2, 1'b0);
    drive(1'b0, 1'b1, 3, 1'b0);
    drive(1'b0, 1'b1, 4, 1'b0);
    drive(1'b0, 1'b1, 15, 1'b0);
    drive(1'b0, 1'b1, 15, 1'b0);
    drive(1'b0, 1'b1, 15, 1'b0);
    drive(1'b0, 1'b1, 15, 1'b1);
    send_window(8, 9, 10, 11);

    // Reset mid-window, then a fresh window.
    drive(1'b0, 1'b1, 12, 1'b1);
    drive(1'b0, 1'b1, 1, 1'b1);
    drive(1'b1, 1'b0, 0, 1'b1);
    send_window(3, 3, 3, 3);

    // Streaming: windows back-to-back with a single bubble per handshake.
    for (int i = 0; i < 20; i++)
      drive(1'b0, 1'b1, int'($urandom_range(0, 15)), 1'b1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++)
      drive(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));

    drive(1'b0, 1'b0, 0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/window_minmax.md
WINDOW_MINMAX -- requirements
Module: window_minmax

Interface
REQ-001 SHALL have parameter WIDTH, default 4, sample width in bits.
REQ-002 SHALL have parameter WIN, default 8, samples per window, legal range 2..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  sample present on in_data.
REQ-006 SHALL have port in_data  input  WIDTH  unsigned sample.
REQ-007 SHALL have port in_ready  output  1  block accepts a sample this cycle.
REQ-008 SHALL have port out_valid  output  1  window result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_min  output  WIDTH  smallest sample in the completed window.
REQ-011 SHALL have port out_max  output  WIDTH  largest sample in the completed window.

Function
REQ-012 SHALL accept a sample only on a cycle where in_valid and in_ready are both 1.
REQ-013 SHALL implement two states: FILL (in_ready=1, out_valid=0) and OUT (in_ready=0, out_valid=1).
REQ-014 SHALL load min=max=in_data on the first accept of each window.
REQ-015 SHALL, on each later accept, update max if in_data > max and min if in_data < min; values equal to min or max leave them unchanged.
REQ-016 SHALL compare unsigned values at full WIDTH, with no wrap-around or saturation.
REQ-017 SHALL keep an accept counter 0..WIN-1; the WIN-th accept clears it and moves FILL->OUT.
REQ-018 SHALL assert out_valid the cycle after the WIN-th accept, with out_min/out_max final on that same cycle.
REQ-019 SHALL hold out_min, out_max and out_valid stable in OUT until out_valid and out_ready are both 1.
REQ-020 SHALL ignore in_valid while in OUT; such samples are not consumed.
REQ-021 SHALL move OUT->FILL on the output handshake, with in_ready=1 on the next cycle and no bubble beyond that cycle.
REQ-022 SHALL not act on out_ready while in FILL.

Reset
REQ-023 SHALL, while rst=1, force in_ready=0 and out_valid=0 regardless of state.
REQ-024 SHALL, on a clock edge with rst=1, set state=FILL, counter=0, out_min=0, out_max=0 and eq_cnt=0.
REQ-025 SHALL discard any partial window and any pending result when reset is asserted mid-operation.

Configuration
REQ-026 SHALL, with macro WINDOW_MINMAX_EQ_CNT_EN defined, add output eq_cnt (width $clog2(WIN+1)) counting non-first accepts whose in_data equals the running max before update; it SHALL be held with the result and cleared at the first accept of the next window.
REQ-027 SHALL, without WINDOW_MINMAX_EQ_CNT_EN, omit the eq_cnt port and its logic entirely, with all other behaviour identical.

Structure
REQ-028 SHALL place the state enum (FILL, OUT) and the default WIDTH/WIN constants in shared package cmp_pkg.
REQ-029 SHALL instantiate sub-module mag_cmp (parameter WIDTH; outputs gt, eq, lt) twice: sample vs max, and sample vs min.

Verification (WIN=4, WIDTH=4, eq_cnt enabled)
REQ-030 SHALL cover: accept 5,2,9,7 -> out_valid the next cycle with out_min=2, out_max=9, eq_cnt=0.
REQ-031 SHALL cover: accept 6,6,6,6 -> out_min=6, out_max=6, eq_cnt=3.
REQ-032 SHALL cover: accept 15,0,15,0 -> out_min=0, out_max=15, eq_cnt=1.
REQ-033 SHALL cover: hold out_ready=0 for 3 cycles in OUT with in_valid=1 -> in_ready=0, outputs unchanged, no samples consumed; the next window result reflects only samples sent after the handshake.
REQ-034 SHALL cover: rst pulse after 2 accepts, then accept 3,3,3,3 -> out_min=3, out_max=3, eq_cnt=3, and no stale result is output.
REQ-035 SHALL cover: continuous in_valid with out_ready=1 -> windows complete back-to-back, each handshake followed one cycle later by in_ready=1 and an accept.
